// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration-time configuration checks for the flagged sync FIFO.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH   = 4;
    localparam int DEF_DATA_DEPTH   = 16;
    localparam int DEF_AFULL_THRESH = 12;
    localparam int DEF_AEMPTY_THRESH = 2;

    // Pointers wrap by natural overflow, so depth must be an exact power of two.
    function automatic bit depth_ok(input int depth, input int aw);
        return depth == (1 << aw);
    endfunction

    function automatic bit thresh_ok(input int depth, input int afull, input int aempty);
        return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
module fifo_ram #(
    parameter int data_width = 8,
    parameter int addr_width = 4,
    parameter int data_depth = 16
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [addr_width-1:0] waddr_i,
    input  logic [data_width-1:0] wdata_i,
    input  logic [addr_width-1:0] raddr_i,
    output logic [data_width-1:0] rdata_o
);

    logic [data_width-1:0] mem_q [data_depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with count-decoded flags, sticky error flags and a build-time
// choice of registered-read or first-word-fall-through output.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int data_width    = DEF_DATA_WIDTH,
    parameter int addr_width    = DEF_ADDR_WIDTH,
    parameter int data_depth    = DEF_DATA_DEPTH,
    parameter int fwft          = 0,
    parameter int afull_thresh  = DEF_AFULL_THRESH,
    parameter int aempty_thresh = DEF_AEMPTY_THRESH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [data_width-1:0] wr_data,
    input  logic                  rd_en,
    output logic [data_width-1:0] rd_data,
    input  logic                  clr_err,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [addr_width:0]   data_count,
    output logic                  overflow,
    output logic                  underflow
);

    if (!depth_ok(data_depth, addr_width)) begin : g_bad_depth
        $error("fifo_sync_flags: data_depth must equal 2**addr_width");
    end
    if (!thresh_ok(data_depth, afull_thresh, aempty_thresh)) begin : g_bad_thresh
        $error("fifo_sync_flags: almost-full/almost-empty threshold out of range");
    end

    localparam logic [addr_width:0] DEPTH_C  = data_depth[addr_width:0];
    localparam logic [addr_width:0] AFULL_C  = afull_thresh[addr_width:0];
    localparam logic [addr_width:0] AEMPTY_C = aempty_thresh[addr_width:0];

    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [addr_width:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_fire, rd_fire;
    logic [data_width-1:0] ram_rdata;

    // The count is the only source of truth; pointer equality is ambiguous after wrap.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign data_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A set in the same cycle as clr_err must not be lost.
        ovf_d = (wr_en & full)  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
        udf_d = (rd_en & empty) ? 1'b1 : (clr_err ? 1'b0 : udf_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .data_width(data_width),
        .addr_width(addr_width),
        .data_depth(data_depth)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    if (fwft == 0) begin : g_std
        logic [data_width-1:0] rd_data_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= '0;
            end else if (rd_fire) begin
                rd_data_q <= ram_rdata;
            end
        end
        assign rd_data = rd_data_q;
    end else begin : g_fwft
        assign rd_data = ram_rdata;
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: one standard-read and one FWFT instance.
module tb_fifo_sync_flags;

    logic       clk;
    logic       rst_n;

    logic       s_wr_en, s_rd_en, s_clr_err;
    logic [7:0] s_wr_data, s_rd_data;
    logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic [4:0] s_count;

    logic       f_wr_en, f_rd_en, f_clr_err;
    logic [7:0] f_wr_data, f_rd_data;
    logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [4:0] f_count;

    int n_checks;
    int n_fails;
    logic [7:0] exp_q[$];

    fifo_sync_flags #(.fwft(0)) u_std (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (s_wr_en),
        .wr_data      (s_wr_data),
        .rd_en        (s_rd_en),
        .rd_data      (s_rd_data),
        .clr_err      (s_clr_err),
        .full         (s_full),
        .empty        (s_empty),
        .almost_full  (s_afull),
        .almost_empty (s_aempty),
        .data_count   (s_count),
        .overflow     (s_ovf),
        .underflow    (s_udf)
    );

    fifo_sync_flags #(.fwft(1)) u_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (f_wr_en),
        .wr_data      (f_wr_data),
        .rd_en        (f_rd_en),
        .rd_data      (f_rd_data),
        .clr_err      (f_clr_err),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_afull),
        .almost_empty (f_aempty),
        .data_count   (f_count),
        .overflow     (f_ovf),
        .underflow    (f_udf)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic s_write(input logic [7:0] d);
        s_wr_en = 1'b1;
        s_wr_data = d;
        step();
        s_wr_en = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_v;
        n_checks = 0;
        n_fails = 0;
        s_wr_en = 0; s_rd_en = 0; s_clr_err = 0; s_wr_data = '0;
        f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_wr_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) step();

        check_eq("rst_empty",  s_empty, 1);
        check_eq("rst_aempty", s_aempty, 1);
        check_eq("rst_full",   s_full, 0);
        check_eq("rst_afull",  s_afull, 0);
        check_eq("rst_count",  s_count, 0);
        check_eq("rst_rdata",  s_rd_data, 0);
        check_eq("rst_ovf",    s_ovf, 0);
        check_eq("rst_udf",    s_udf, 0);
        rst_n = 1'b1;
        step();
        check_eq("idle_empty", s_empty, 1);
        check_eq("idle_count", s_count, 0);

        // Fill 0..15
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1'b1;
            s_wr_data = i[7:0];
            step();
            check_eq("fill_count",  s_count, i + 1);
            check_eq("fill_afull",  s_afull, (i + 1 >= 12) ? 1 : 0);
            check_eq("fill_aempty", s_aempty, (i + 1 <= 2) ? 1 : 0);
            check_eq("fill_full",   s_full, (i == 15) ? 1 : 0);
            check_eq("fill_empty",  s_empty, 0);
        end
        s_wr_data = 8'hAA;
        step();
        s_wr_en = 1'b0;
        check_eq("ovf_set",   s_ovf, 1);
        check_eq("ovf_count", s_count, 16);
        check_eq("ovf_full",  s_full, 1);
        check_eq("ovf_udf",   s_udf, 0);

        // Drain in order, one cycle read latency
        for (int i = 0; i < 16; i++) begin
            s_rd_en = 1'b1;
            step();
            check_eq("drain_data",  s_rd_data, i);
            check_eq("drain_count", s_count, 15 - i);
        end
        s_rd_en = 1'b0;
        check_eq("drain_empty", s_empty, 1);
        step();
        check_eq("hold_data", s_rd_data, 8'd15);

        s_rd_en = 1'b1;
        step();
        s_rd_en = 1'b0;
        check_eq("udf_set",   s_udf, 1);
        check_eq("udf_ovf",   s_ovf, 1);
        check_eq("udf_count", s_count, 0);
        check_eq("udf_data",  s_rd_data, 8'd15);
        s_clr_err = 1'b1;
        step();
        s_clr_err = 1'b0;
        check_eq("clr_ovf", s_ovf, 0);
        check_eq("clr_udf", s_udf, 0);

        // Set beats clear in the same cycle
        s_clr_err = 1'b1;
        s_rd_en = 1'b1;
        step();
        s_rd_en = 1'b0;
        check_eq("setwins_udf", s_udf, 1);
        step();
        s_clr_err = 1'b0;
        check_eq("clr2_udf", s_udf, 0);

        // Empty with both requests: write accepted, read flagged
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 8'd100;
        step();
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        exp_q.push_back(8'd100);
        check_eq("both_empty_count", s_count, 1);
        check_eq("both_empty_udf",   s_udf, 1);
        check_eq("both_empty_data",  s_rd_data, 8'd15);
        s_clr_err = 1'b1;
        step();
        s_clr_err = 1'b0;

        for (int i = 1; i < 5; i++) begin
            s_write(8'(100 + i));
            exp_q.push_back(8'(100 + i));
        end
        check_eq("c5_count", s_count, 5);

        // Steady state at count 5 across pointer wrap
        for (int i = 0; i < 20; i++) begin
            s_wr_en = 1'b1; s_rd_en = 1'b1;
            s_wr_data = 8'(105 + i);
            exp_q.push_back(8'(105 + i));
            step();
            exp_v = exp_q.pop_front();
            check_eq("bb_data",  s_rd_data, exp_v);
            check_eq("bb_count", s_count, 5);
        end
        s_wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_v = exp_q.pop_front();
            check_eq("bb_tail", s_rd_data, exp_v);
        end
        s_rd_en = 1'b0;
        check_eq("bb_empty", s_empty, 1);
        check_eq("bb_udf",   s_udf, 0);

        // FWFT instance
        check_eq("fw_rst_empty", f_empty, 1);
        f_wr_en = 1'b1; f_wr_data = 8'd88;
        step();
        f_wr_en = 1'b0;
        check_eq("fw_data",  f_rd_data, 8'd88);
        check_eq("fw_empty", f_empty, 0);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        check_eq("fw_empty_after", f_empty, 1);
        check_eq("fw_udf", f_udf, 0);
        f_wr_en = 1'b1; f_wr_data = 8'h11;
        step();
        f_wr_data = 8'h22;
        step();
        f_wr_en = 1'b0;
        check_eq("fw_head1", f_rd_data, 8'h11);
        check_eq("fw_cnt2",  f_count, 2);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        check_eq("fw_head2", f_rd_data, 8'h22);
        check_eq("fw_cnt1",  f_count, 1);

        // Asynchronous reset at count 9
        for (int i = 0; i < 9; i++) begin
            s_write(8'(200 + i));
        end
        check_eq("pre_rst_count", s_count, 9);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_full",  s_full, 0);
        check_eq("arst_empty", s_empty, 1);
        check_eq("arst_count", s_count, 0);
        check_eq("arst_rdata", s_rd_data, 0);
        check_eq("arst_fw_empty", f_empty, 1);
        step();
        rst_n = 1'b1;
        step();
        s_write(8'h5A);
        s_write(8'h3C);
        check_eq("post_rst_count", s_count, 2);
        s_rd_en = 1'b1;
        step();
        check_eq("post_rst_first", s_rd_data, 8'h5A);
        step();
        s_rd_en = 1'b0;
        check_eq("post_rst_second", s_rd_data, 8'h3C);
        check_eq("post_rst_empty",  s_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
